// File: rtl/vc_input_ctrl_pkg.sv
// Shared types and sizing for the per-VC input control stage.
// Flit format, flit labels and the control FSM state encoding live here.
package vc_input_ctrl_pkg;

  localparam int VC_NUM   = 4;
  localparam int VC_DEPTH = 4;
  localparam int DEST_W   = 4;
  localparam int DATA_W   = 16;
  localparam int VC_W     = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VA     = 2'd1,
    ACTIVE = 2'd2
  } vc_ctrl_state_t;

  typedef struct packed {
    flit_label_t       label;
    logic [VC_W-1:0]   vc_id;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } flit_t;

  function automatic logic is_head(flit_label_t label);
    return (label == HEAD) || (label == HEADTAIL);
  endfunction

  function automatic logic is_tail(flit_label_t label);
    return (label == TAIL) || (label == HEADTAIL);
  endfunction

endpackage

// File: rtl/vc_input_ctrl_if.sv
// Flit stream toward the switch: valid/flit forward, ready back.
interface vc_input_ctrl_if;
  import vc_input_ctrl_pkg::*;

  logic  flit_valid;
  flit_t flit;
  logic  flit_ready;

  modport master (output flit_valid, output flit, input flit_ready);
  modport slave  (input flit_valid, input flit, output flit_ready);

endinterface

// File: rtl/vc_input_ctrl.sv
// Per-VC input control: pops the VC buffer, holds the head flit through VC allocation,
// then streams the packet to the switch. Optional checking under VC_INPUT_CTRL_ERR_CHECK_EN.
module vc_input_ctrl
  import vc_input_ctrl_pkg::*;
#(
  parameter int VC_NUM = vc_input_ctrl_pkg::VC_NUM,
  localparam int OUT_VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                buf_empty_i,
  input  flit_t               buf_data_i,
  output logic                buf_read_o,
  output logic                credit_o,
  output logic                va_req_o,
  output logic [DEST_W-1:0]   va_dest_o,
  input  logic                va_grant_i,
  input  logic [OUT_VC_W-1:0] va_out_vc_i,
  vc_input_ctrl_if.master     sw,
  output logic                error_o
);

  vc_ctrl_state_t      state_reg, state_next;
  logic                pending_reg;
  logic                hold_valid_reg;
  flit_t               hold_reg;
  logic [OUT_VC_W-1:0] out_vc_reg;

  flit_t cur_flit;
  flit_t out_flit;
  logic  cur_valid;
  logic  cur_head;
  logic  cur_tail;
  logic  bad_in_idle;
  logic  bad_in_active;

  logic  va_req;
  logic  flit_valid;
  logic  fire;
  logic  drop;
  logic  grant_take;
  logic  consume;
  logic  buf_read;

  // Data from the buffer is only valid the cycle after the read; otherwise use the held copy.
  assign cur_flit  = pending_reg ? buf_data_i : hold_reg;
  assign cur_valid = pending_reg | hold_valid_reg;
  assign cur_head  = is_head(cur_flit.label);
  assign cur_tail  = is_tail(cur_flit.label);

`ifdef VC_INPUT_CTRL_ERR_CHECK_EN
  assign bad_in_idle   = ~cur_head;
  assign bad_in_active = cur_head;
`else
  assign bad_in_idle   = 1'b0;
  assign bad_in_active = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    va_req     = 1'b0;
    flit_valid = 1'b0;
    fire       = 1'b0;
    drop       = 1'b0;
    grant_take = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (cur_valid) begin
          if (bad_in_idle) begin
            drop = 1'b1;
          end else begin
            va_req = 1'b1;
            if (va_grant_i) begin
              grant_take = 1'b1;
              state_next = ACTIVE;
            end else begin
              state_next = VA;
            end
          end
        end
      end
      VA: begin
        va_req = 1'b1;
        if (va_grant_i) begin
          grant_take = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cur_valid && bad_in_active) begin
          drop = 1'b1;
        end else begin
          flit_valid = cur_valid;
          fire       = cur_valid & sw.flit_ready;
          if (fire && cur_tail) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign consume = fire | drop;
  // Reads are suppressed during reset so no credit escapes on the reset cycle.
  assign buf_read = ~rst & ~buf_empty_i & (~cur_valid | consume) & (state_reg != VA);

  always_comb begin
    out_flit       = cur_flit;
    out_flit.vc_id = VC_W'(out_vc_reg);
  end

  assign buf_read_o    = buf_read;
  assign credit_o      = buf_read;
  assign va_req_o      = va_req;
  assign va_dest_o     = va_req ? cur_flit.dest : '0;
  assign sw.flit_valid = flit_valid;
  assign sw.flit       = flit_valid ? out_flit : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      pending_reg    <= 1'b0;
      hold_valid_reg <= 1'b0;
      hold_reg       <= '0;
      out_vc_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= buf_read;
      if (grant_take) begin
        out_vc_reg <= va_out_vc_i;
      end
      // A pending flit that is not consumed must be captured before the buffer output moves on.
      if (pending_reg && !consume) begin
        hold_reg       <= buf_data_i;
        hold_valid_reg <= 1'b1;
      end else if (consume) begin
        hold_valid_reg <= 1'b0;
      end
    end
  end

`ifdef VC_INPUT_CTRL_ERR_CHECK_EN
  logic error_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      error_reg <= 1'b0;
    end else if (drop) begin
      error_reg <= 1'b1;
    end
  end

  assign error_o = error_reg;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_vc_input_ctrl.sv
// Directed bench for vc_input_ctrl with a buffer model and a flit scoreboard.
module tb_vc_input_ctrl;
  import vc_input_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              buf_empty_i;
  flit_t             buf_data_i;
  logic              buf_read_o;
  logic              credit_o;
  logic              va_req_o;
  logic [DEST_W-1:0] va_dest_o;
  logic              va_grant_i;
  logic [VC_W-1:0]   va_out_vc_i;
  logic              error_o;

  vc_input_ctrl_if sw();

  always #5 clk = ~clk;

  vc_input_ctrl #(.VC_NUM(VC_NUM)) dut (
    .clk         (clk),
    .rst         (rst),
    .buf_empty_i (buf_empty_i),
    .buf_data_i  (buf_data_i),
    .buf_read_o  (buf_read_o),
    .credit_o    (credit_o),
    .va_req_o    (va_req_o),
    .va_dest_o   (va_dest_o),
    .va_grant_i  (va_grant_i),
    .va_out_vc_i (va_out_vc_i),
    .sw          (sw),
    .error_o     (error_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  flit_t           buf_q[$];
  flit_t           exp_q[$];
  logic [VC_W-1:0] grant_q[$];

  int    cyc = 0;
  int    grant_delay = 0;
  int    ready_mode = 0;
  int    req_run, last_req_run, req_episodes, reads_in_req;
  int    credits, reads, fires, empty_reads, stall_checks;
  int    first_read_cyc, first_req_cyc, first_fire_cyc, last_fire_cyc;
  int    first_req_dest;
  logic  stalled;
  flit_t stalled_flit;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    req_run = 0; last_req_run = 0; req_episodes = 0; reads_in_req = 0;
    credits = 0; reads = 0; fires = 0; empty_reads = 0; stall_checks = 0;
    first_read_cyc = -1; first_req_cyc = -1; first_fire_cyc = -1; last_fire_cyc = -1;
    first_req_dest = -1;
    stalled = 1'b0;
  endtask

  task automatic push_flit(flit_label_t label, logic [DEST_W-1:0] dest, logic [DATA_W-1:0] data,
                           logic [VC_W-1:0] gvc, bit expect_out);
    flit_t f;
    f.label = label;
    f.vc_id = ~gvc;
    f.dest  = dest;
    f.data  = data;
    buf_q.push_back(f);
    if (expect_out) begin
      f.vc_id = gvc;
      exp_q.push_back(f);
    end
    buf_empty_i = 1'b0;
  endtask

  // One clock cycle: entered and left at a negedge.
  task automatic tick();
    logic  rd;
    flit_t exp_f;
    case (ready_mode)
      0:       sw.flit_ready = 1'b1;
      1:       sw.flit_ready = (cyc % 2 == 0);
      default: sw.flit_ready = 1'b0;
    endcase
    if (va_req_o && grant_q.size() > 0 && req_run >= grant_delay) begin
      va_grant_i  = 1'b1;
      va_out_vc_i = grant_q[0];
    end else begin
      va_grant_i  = 1'b0;
      va_out_vc_i = '0;
    end
    #1;
    rd = buf_read_o;
    if (rd) begin
      reads++;
      if (first_read_cyc < 0) first_read_cyc = cyc;
      if (buf_empty_i) empty_reads++;
    end
    if (credit_o) credits++;
    if (va_req_o) begin
      if (rd) reads_in_req++;
      if (req_run == 0) req_episodes++;
      if (first_req_cyc < 0) begin
        first_req_cyc  = cyc;
        first_req_dest = int'(va_dest_o);
      end
      req_run++;
      if (va_grant_i) begin
        last_req_run = req_run;
        req_run = 0;
        void'(grant_q.pop_front());
      end
    end
    if (stalled) begin
      stall_checks++;
      check("stall_valid", 64'(sw.flit_valid), 64'd1);
      check("stall_flit", 64'(sw.flit), 64'(stalled_flit));
    end
    if (sw.flit_valid && sw.flit_ready) begin
      fires++;
      if (first_fire_cyc < 0) first_fire_cyc = cyc;
      last_fire_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_flit", 64'(sw.flit), 64'd0 - 64'd1);
      end else begin
        exp_f = exp_q.pop_front();
        check("flit", 64'(sw.flit), 64'(exp_f));
      end
    end
    stalled      = sw.flit_valid && !sw.flit_ready;
    stalled_flit = sw.flit;
    @(posedge clk);
    #1;
    if (rd && buf_q.size() > 0) buf_data_i = buf_q.pop_front();
    buf_empty_i = (buf_q.size() == 0);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_read"},   64'(buf_read_o),    64'd0);
    check({tag, "_credit"}, 64'(credit_o),      64'd0);
    check({tag, "_vareq"},  64'(va_req_o),      64'd0);
    check({tag, "_vadest"}, 64'(va_dest_o),     64'd0);
    check({tag, "_valid"},  64'(sw.flit_valid), 64'd0);
    check({tag, "_flit"},   64'(sw.flit),       64'd0);
    check({tag, "_error"},  64'(error_o),       64'd0);
  endtask

  initial begin
    rst           = 1'b1;
    buf_empty_i   = 1'b1;
    buf_data_i    = '0;
    va_grant_i    = 1'b0;
    va_out_vc_i   = '0;
    sw.flit_ready = 1'b0;
    clear_stats();
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: three-flit packet, same-cycle grant, ready always high
    clear_stats();
    grant_delay = 0;
    ready_mode  = 0;
    grant_q.push_back(2'd2);
    push_flit(HEAD, 4'd5, 16'h1111, 2'd2, 1);
    push_flit(BODY, 4'd5, 16'h2222, 2'd2, 1);
    push_flit(TAIL, 4'd5, 16'h3333, 2'd2, 1);
    run(8);
    check("t1_req_latency",  64'(first_req_cyc - first_read_cyc), 64'd1);
    check("t1_first_fire",   64'(first_fire_cyc - first_read_cyc), 64'd2);
    check("t1_last_fire",    64'(last_fire_cyc - first_read_cyc), 64'd4);
    check("t1_req_dest",     64'(first_req_dest), 64'd5);
    check("t1_fires",        64'(fires), 64'd3);
    check("t1_credits",      64'(credits), 64'd3);
    check("t1_credit_eq_rd", 64'(credits), 64'(reads));
    check("t1_sb_empty",     64'(exp_q.size()), 64'd0);

    // 2: two HEADTAIL packets, grant delayed 5 cycles each
    clear_stats();
    grant_delay = 5;
    grant_q.push_back(2'd1);
    grant_q.push_back(2'd1);
    push_flit(HEADTAIL, 4'd3, 16'hAAAA, 2'd1, 1);
    push_flit(HEADTAIL, 4'd7, 16'hBBBB, 2'd1, 1);
    run(24);
    check("t2_req_dest",     64'(first_req_dest), 64'd3);
    check("t2_req_run",      64'(last_req_run), 64'd6);
    check("t2_episodes",     64'(req_episodes), 64'd2);
    check("t2_reads_in_req", 64'(reads_in_req), 64'd0);
    check("t2_fires",        64'(fires), 64'd2);
    check("t2_credits",      64'(credits), 64'd2);
    check("t2_idle_req",     64'(va_req_o), 64'd0);
    check("t2_idle_valid",   64'(sw.flit_valid), 64'd0);

    // 3: four-flit packet with toggling ready
    clear_stats();
    grant_delay = 0;
    ready_mode  = 1;
    grant_q.push_back(2'd0);
    push_flit(HEAD, 4'd9, 16'h0A01, 2'd0, 1);
    push_flit(BODY, 4'd9, 16'h0A02, 2'd0, 1);
    push_flit(BODY, 4'd9, 16'h0A03, 2'd0, 1);
    push_flit(TAIL, 4'd9, 16'h0A04, 2'd0, 1);
    run(16);
    check("t3_fires",     64'(fires), 64'd4);
    check("t3_credits",   64'(credits), 64'd4);
    check("t3_stall_seen", 64'(stall_checks > 0), 64'd1);
    check("t3_sb_empty",  64'(exp_q.size()), 64'd0);

    // 4: back-to-back packets get separate grants
    clear_stats();
    ready_mode = 0;
    grant_q.push_back(2'd1);
    grant_q.push_back(2'd3);
    push_flit(HEAD, 4'd2, 16'hC001, 2'd1, 1);
    push_flit(TAIL, 4'd2, 16'hC002, 2'd1, 1);
    push_flit(HEAD, 4'd4, 16'hD001, 2'd3, 1);
    push_flit(BODY, 4'd4, 16'hD002, 2'd3, 1);
    push_flit(TAIL, 4'd4, 16'hD003, 2'd3, 1);
    run(14);
    check("t4_episodes",  64'(req_episodes), 64'd2);
    check("t4_fires",     64'(fires), 64'd5);
    check("t4_credits",   64'(credits), 64'd5);
    check("t4_empty_rd",  64'(empty_reads), 64'd0);
    check("t4_sb_empty",  64'(exp_q.size()), 64'd0);

    // 5: reset in the middle of an active packet
    clear_stats();
    grant_q.push_back(2'd2);
    push_flit(HEAD, 4'd1, 16'hE001, 2'd2, 1);
    push_flit(BODY, 4'd1, 16'hE002, 2'd2, 1);
    push_flit(BODY, 4'd1, 16'hE003, 2'd2, 1);
    push_flit(TAIL, 4'd1, 16'hE004, 2'd2, 1);
    for (int i = 0; i < 20 && fires < 2; i++) tick();
    check("t5_fires_before_rst", 64'(fires), 64'd2);
    rst = 1'b1;
    sw.flit_ready = 1'b1;
    va_grant_i    = 1'b0;
    #1;
    check("t5_rst_credit", 64'(credit_o), 64'd0);
    check("t5_rst_read",   64'(buf_read_o), 64'd0);
    @(posedge clk);
    #1;
    buf_q.delete();
    exp_q.delete();
    grant_q.delete();
    buf_data_i  = '0;
    buf_empty_i = 1'b1;
    check_outputs_zero("t5_after_rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs_zero("t5_idle");
    @(negedge clk);

    // 6: BODY flit arriving in IDLE
    clear_stats();
`ifdef VC_INPUT_CTRL_ERR_CHECK_EN
    push_flit(BODY, 4'd6, 16'hF00D, 2'd2, 0);
    run(6);
    check("t6_credits",  64'(credits), 64'd1);
    check("t6_fires",    64'(fires), 64'd0);
    check("t6_episodes", 64'(req_episodes), 64'd0);
    check("t6_error",    64'(error_o), 64'd1);
    run(3);
    check("t6_error_sticky", 64'(error_o), 64'd1);
`else
    grant_q.push_back(2'd2);
    push_flit(BODY, 4'd6, 16'hF00D, 2'd2, 1);
    run(8);
    check("t6_credits",  64'(credits), 64'd1);
    check("t6_episodes", 64'(req_episodes), 64'd1);
    check("t6_req_dest", 64'(first_req_dest), 64'd6);
    check("t6_fires",    64'(fires), 64'd1);
    check("t6_error",    64'(error_o), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
